// File: rtl/upc_pkg.sv
// Shared types and default constants for the UPC checkout monitor.
// The item struct is sized for the widest supported code; narrower builds zero-extend.
package upc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam int UPC_MAX_W = 16;
  localparam int DEF_UPC_W = 3;

  typedef struct packed {
    logic [UPC_MAX_W-1:0] code;
    logic                 mark;
  } item_t;

  localparam logic [7:0] DEF_DISC_MASK = 8'b0011_0010;
  localparam logic [7:0] DEF_EXP_MASK  = 8'b1010_0001;

endpackage

// File: rtl/upc_checkout_monitor_if.sv
// Item handshake between the scan front end (master) and the checkout monitor (slave).
// Valid/ready: an item transfers on a rising clk edge where in_valid and in_ready are both 1;
// the master holds in_code/in_mark stable while in_valid=1 and in_ready=0.
interface upc_checkout_monitor_if #(
  parameter int UPC_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [UPC_W-1:0] in_code;
  logic             in_mark;

  modport master (output in_valid, output in_code, output in_mark, input in_ready);
  modport slave  (input in_valid, input in_code, input in_mark, output in_ready);
endinterface

// File: rtl/upc_classifier.sv
// Combinational item classifier: looks the code up in the discount and expensive masks.
module upc_classifier
  import upc_pkg::*;
#(
  parameter int                   UPC_W     = DEF_UPC_W,
  parameter logic [2**UPC_W-1:0]  DISC_MASK = DEF_DISC_MASK,
  parameter logic [2**UPC_W-1:0]  EXP_MASK  = DEF_EXP_MASK
) (
  input  item_t item,
  output logic  discounted,
  output logic  stolen
);
  logic [UPC_W-1:0] code;
  logic             unused_code_hi;

  assign code           = item.code[UPC_W-1:0];
  // Upper struct bits are zero-extension padding and carry no information.
  assign unused_code_hi = ^item.code;

  assign discounted = DISC_MASK[code];
  assign stolen     = EXP_MASK[code] & ~item.mark;
endmodule

// File: rtl/upc_checkout_monitor.sv
// Sequential checkout monitor: captures one item, classifies it, counts it, and holds an alarm on theft.
// Define UPC_ALARM_ACK_EN to require an operator acknowledge before leaving ALARM.
module upc_checkout_monitor
  import upc_pkg::*;
#(
  parameter int                   UPC_W      = DEF_UPC_W,
  parameter int                   CNT_W      = 8,
  parameter logic [2**UPC_W-1:0]  DISC_MASK  = DEF_DISC_MASK,
  parameter logic [2**UPC_W-1:0]  EXP_MASK   = DEF_EXP_MASK,
  parameter int                   ALARM_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  upc_checkout_monitor_if.slave  bus,
  input  logic                   clear,
  input  logic                   alarm_ack,
  output logic                   disc,
  output logic                   stolen,
  output logic                   alarm,
  output logic [CNT_W-1:0]       item_cnt,
  output logic [CNT_W-1:0]       disc_cnt,
  output logic [CNT_W-1:0]       stolen_cnt,
  output state_t                 dbg_state
);
  localparam int                HOLD_W    = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ALARM_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state, state_nx;
  item_t             item_r;
  logic [HOLD_W-1:0] hold;
  logic              accept;
  logic              cls_disc, cls_stolen;
  logic              hold_done;
  logic              alarm_exit;

  upc_classifier #(
    .UPC_W     (UPC_W),
    .DISC_MASK (DISC_MASK),
    .EXP_MASK  (EXP_MASK)
  ) u_classifier (
    .item       (item_r),
    .discounted (cls_disc),
    .stolen     (cls_stolen)
  );

  // in_ready and alarm decode straight from the state register, so no input reaches an output.
  assign bus.in_ready = (state == IDLE);
  assign alarm        = (state == ALARM);
  assign dbg_state    = state;
  assign accept       = bus.in_valid & (state == IDLE);
  assign hold_done    = (hold == '0);

`ifdef UPC_ALARM_ACK_EN
  assign alarm_exit = hold_done & alarm_ack;
`else
  logic unused_alarm_ack;
  assign unused_alarm_ack = alarm_ack;
  assign alarm_exit       = hold_done;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CHECK;
      CHECK:   state_nx = cls_stolen ? ALARM : IDLE;
      ALARM:   if (alarm_exit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      item_r     <= '0;
      hold       <= '0;
      disc       <= 1'b0;
      stolen     <= 1'b0;
      item_cnt   <= '0;
      disc_cnt   <= '0;
      stolen_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        item_r.code <= UPC_MAX_W'(bus.in_code);
        item_r.mark <= bus.in_mark;
      end
      // Hold is loaded while leaving CHECK so it reads ALARM_HOLD-1 on the first ALARM cycle.
      if (state == CHECK) hold <= HOLD_LOAD;
      else if (state == ALARM && !hold_done) hold <= hold - 1'b1;
      if (state == CHECK) begin
        disc   <= cls_disc;
        stolen <= cls_stolen;
      end
      // clear takes priority over a same-cycle CHECK update.
      if (clear) begin
        item_cnt   <= '0;
        disc_cnt   <= '0;
        stolen_cnt <= '0;
      end else if (state == CHECK) begin
        if (item_cnt != CNT_MAX) item_cnt <= item_cnt + 1'b1;
        if (cls_disc && disc_cnt != CNT_MAX) disc_cnt <= disc_cnt + 1'b1;
        if (cls_stolen && stolen_cnt != CNT_MAX) stolen_cnt <= stolen_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_upc_checkout_monitor.sv
// Directed bench for upc_checkout_monitor: a default instance plus a CNT_W=2 instance fed the same stimulus.
module tb_upc_checkout_monitor;
  import upc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic alarm_ack;
  int   checks = 0;
  int   errors = 0;

  upc_checkout_monitor_if #(.UPC_W(3)) m_if ();
  upc_checkout_monitor_if #(.UPC_W(3)) s_if ();

  logic       m_disc, m_stolen, m_alarm;
  logic [7:0] m_item_cnt, m_disc_cnt, m_stolen_cnt;
  state_t     m_state;
  logic       s_disc, s_stolen, s_alarm;
  logic [1:0] s_item_cnt, s_disc_cnt, s_stolen_cnt;
  state_t     s_state;

  assign s_if.in_valid = m_if.in_valid;
  assign s_if.in_code  = m_if.in_code;
  assign s_if.in_mark  = m_if.in_mark;

  upc_checkout_monitor #(.UPC_W(3), .CNT_W(8), .ALARM_HOLD(4)) dut (
    .clk(clk), .reset(reset), .bus(m_if.slave), .clear(clear), .alarm_ack(alarm_ack),
    .disc(m_disc), .stolen(m_stolen), .alarm(m_alarm),
    .item_cnt(m_item_cnt), .disc_cnt(m_disc_cnt), .stolen_cnt(m_stolen_cnt),
    .dbg_state(m_state)
  );

  upc_checkout_monitor #(.UPC_W(3), .CNT_W(2), .ALARM_HOLD(4)) dut_sat (
    .clk(clk), .reset(reset), .bus(s_if.slave), .clear(clear), .alarm_ack(alarm_ack),
    .disc(s_disc), .stolen(s_stolen), .alarm(s_alarm),
    .item_cnt(s_item_cnt), .disc_cnt(s_disc_cnt), .stolen_cnt(s_stolen_cnt),
    .dbg_state(s_state)
  );

  // Clock and run-time bound
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Driver tasks: inputs change 1 time unit after a rising edge, outputs are sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_item(input logic [2:0] code, input logic mark);
    m_if.in_valid = 1'b1;
    m_if.in_code  = code;
    m_if.in_mark  = mark;
    step();
    m_if.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    m_if.in_valid = 1'b0;
    m_if.in_code  = '0;
    m_if.in_mark  = 1'b0;
    clear     = 1'b0;
    alarm_ack = 1'b0;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (m_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", m_if.in_ready); end
    checks++; if ({m_disc, m_stolen, m_alarm} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {m_disc, m_stolen, m_alarm}); end
    checks++; if ({m_item_cnt, m_disc_cnt, m_stolen_cnt} !== 24'd0) begin errors++; $display("FAIL reset_counts got=%h exp=0", {m_item_cnt, m_disc_cnt, m_stolen_cnt}); end
    checks++; if (m_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", m_state, IDLE); end
  endtask

  task automatic test_discount();
    send_item(3'b001, 1'b1);
    checks++; if ({m_disc, m_stolen, m_alarm} !== 3'b100) begin errors++; $display("FAIL disc_flags got=%b exp=100", {m_disc, m_stolen, m_alarm}); end
    checks++; if (m_item_cnt !== 8'd1) begin errors++; $display("FAIL disc_item_cnt got=%0d exp=1", m_item_cnt); end
    checks++; if (m_disc_cnt !== 8'd1) begin errors++; $display("FAIL disc_disc_cnt got=%0d exp=1", m_disc_cnt); end
    checks++; if (m_stolen_cnt !== 8'd0) begin errors++; $display("FAIL disc_stolen_cnt got=%0d exp=0", m_stolen_cnt); end
    checks++; if (m_if.in_ready !== 1'b1) begin errors++; $display("FAIL disc_ready got=%0b exp=1", m_if.in_ready); end
  endtask

  task automatic test_stolen_alarm();
    send_item(3'b000, 1'b0);
    checks++; if ({m_disc, m_stolen} !== 2'b01) begin errors++; $display("FAIL steal_flags got=%b exp=01", {m_disc, m_stolen}); end
    checks++; if ({m_item_cnt, m_disc_cnt, m_stolen_cnt} !== {8'd2, 8'd1, 8'd1}) begin errors++; $display("FAIL steal_counts got=%h exp=020101", {m_item_cnt, m_disc_cnt, m_stolen_cnt}); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({m_alarm, m_if.in_ready} !== 2'b10) begin errors++; $display("FAIL steal_hold_%0d alarm_ready got=%b exp=10", i, {m_alarm, m_if.in_ready}); end
      alarm_ack = (i == 1);
      step();
    end
    alarm_ack = 1'b0;
`ifdef UPC_ALARM_ACK_EN
    checks++; if ({m_alarm, m_if.in_ready} !== 2'b10) begin errors++; $display("FAIL steal_wait_ack got=%b exp=10", {m_alarm, m_if.in_ready}); end
    step();
    checks++; if (m_alarm !== 1'b1) begin errors++; $display("FAIL steal_still_alarm got=%0b exp=1", m_alarm); end
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
`endif
    checks++; if ({m_alarm, m_if.in_ready} !== 2'b01) begin errors++; $display("FAIL steal_exit got=%b exp=01", {m_alarm, m_if.in_ready}); end
    checks++; if (m_stolen !== 1'b1) begin errors++; $display("FAIL steal_flag_kept got=%0b exp=1", m_stolen); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] codes [5];
    codes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if ({s_item_cnt, s_disc_cnt, s_stolen_cnt} !== 6'd0) begin errors++; $display("FAIL b2b_clear got=%b exp=0", {s_item_cnt, s_disc_cnt, s_stolen_cnt}); end
    m_if.in_valid = 1'b1;
    m_if.in_mark  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_if.in_code = codes[i];
      checks++; if (m_if.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got=%0b exp=1", i, m_if.in_ready); end
      step();
      step();
    end
    m_if.in_valid = 1'b0;
    checks++; if (m_item_cnt !== 8'd5) begin errors++; $display("FAIL b2b_item_cnt got=%0d exp=5", m_item_cnt); end
    checks++; if (s_item_cnt !== 2'd3) begin errors++; $display("FAIL b2b_sat_item_cnt got=%0d exp=3", s_item_cnt); end
    checks++; if ({m_disc_cnt, s_disc_cnt} !== {8'd2, 2'd2}) begin errors++; $display("FAIL b2b_disc_cnt got=%h exp=2,2", {m_disc_cnt, s_disc_cnt}); end
    checks++; if ({m_disc, m_stolen, m_stolen_cnt} !== 10'd0) begin errors++; $display("FAIL b2b_last_flags got=%b exp=0", {m_disc, m_stolen, m_stolen_cnt}); end
  endtask

  task automatic test_clear_in_check();
    m_if.in_valid = 1'b1;
    m_if.in_code  = 3'd5;
    m_if.in_mark  = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    checks++; if (m_state !== CHECK) begin errors++; $display("FAIL clr_in_check_state got=%0d exp=%0d", m_state, CHECK); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if ({m_item_cnt, m_disc_cnt, m_stolen_cnt} !== 24'd0) begin errors++; $display("FAIL clr_counts got=%h exp=0", {m_item_cnt, m_disc_cnt, m_stolen_cnt}); end
    checks++; if ({s_item_cnt, s_disc_cnt, s_stolen_cnt} !== 6'd0) begin errors++; $display("FAIL clr_sat_counts got=%b exp=0", {s_item_cnt, s_disc_cnt, s_stolen_cnt}); end
    checks++; if ({m_disc, m_stolen, s_disc} !== 3'b101) begin errors++; $display("FAIL clr_flags got=%b exp=101", {m_disc, m_stolen, s_disc}); end
    checks++; if (m_state !== IDLE) begin errors++; $display("FAIL clr_state got=%0d exp=%0d", m_state, IDLE); end
  endtask

  task automatic test_reset_in_check();
    send_item(3'd4, 1'b1);
    checks++; if ({m_item_cnt, m_disc} !== {8'd1, 1'b1}) begin errors++; $display("FAIL rst_chk_pre got=%h exp=1,1", {m_item_cnt, m_disc}); end
    m_if.in_valid = 1'b1;
    m_if.in_code  = 3'd2;
    m_if.in_mark  = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if ({m_state, m_if.in_ready} !== {IDLE, 1'b1}) begin errors++; $display("FAIL rst_chk_state got=%b exp=%b", {m_state, m_if.in_ready}, {IDLE, 1'b1}); end
    checks++; if ({m_disc, m_stolen, m_alarm} !== 3'b000) begin errors++; $display("FAIL rst_chk_flags got=%b exp=000", {m_disc, m_stolen, m_alarm}); end
    step();
    checks++; if ({m_item_cnt, m_disc_cnt} !== 16'd0) begin errors++; $display("FAIL rst_chk_counts got=%h exp=0", {m_item_cnt, m_disc_cnt}); end
  endtask

  task automatic test_reset_in_alarm();
    send_item(3'd7, 1'b0);
    checks++; if ({m_alarm, m_stolen} !== 2'b11) begin errors++; $display("FAIL rst_alm_pre got=%b exp=11", {m_alarm, m_stolen}); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if ({m_alarm, m_stolen, m_if.in_ready} !== 3'b001) begin errors++; $display("FAIL rst_alm_flags got=%b exp=001", {m_alarm, m_stolen, m_if.in_ready}); end
    checks++; if ({m_item_cnt, m_stolen_cnt} !== 16'd0) begin errors++; $display("FAIL rst_alm_counts got=%h exp=0", {m_item_cnt, m_stolen_cnt}); end
  endtask

  task automatic test_valid_in_alarm();
    send_item(3'd5, 1'b0);
    checks++; if ({m_disc, m_stolen, m_alarm} !== 3'b111) begin errors++; $display("FAIL via_flags got=%b exp=111", {m_disc, m_stolen, m_alarm}); end
    m_if.in_valid = 1'b1;
    m_if.in_mark  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_if.in_code = 3'(i);
`ifdef UPC_ALARM_ACK_EN
      alarm_ack = (i == 3);
`endif
      checks++; if ({m_if.in_ready, m_item_cnt, m_stolen_cnt} !== {1'b0, 8'd1, 8'd1}) begin errors++; $display("FAIL via_hold_%0d got=%h exp=0,1,1", i, {m_if.in_ready, m_item_cnt, m_stolen_cnt}); end
      step();
    end
    m_if.in_valid = 1'b0;
    alarm_ack     = 1'b0;
    checks++; if (m_state !== IDLE) begin errors++; $display("FAIL via_exit_state got=%0d exp=%0d", m_state, IDLE); end
    step();
    step();
    checks++; if ({m_item_cnt, m_disc_cnt, m_stolen_cnt} !== {8'd1, 8'd1, 8'd1}) begin errors++; $display("FAIL via_no_capture got=%h exp=010101", {m_item_cnt, m_disc_cnt, m_stolen_cnt}); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_discount();
    test_stolen_alarm();
    test_back_to_back();
    test_clear_in_check();
    test_reset_in_check();
    test_reset_in_alarm();
    test_valid_in_alarm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/upc_checkout_monitor.md
# upc_checkout_monitor

Sequential successor to the combinational discounted/stolen detector. Items arrive one at a time over a valid/ready handshake: a UPC code of parametrised width plus a "marked" bit. The block classifies each item, keeps saturating running counts, and raises a stolen-item alarm that blocks further scans. It sits between the switch/scan front end and the seg7/LEDR display logic of the DE1_SoC top level.

## Interface
Parameters:
- UPC_W, 3: UPC code width in bits.
- CNT_W, 8: width of each running counter.
- DISC_MASK, 8'b0011_0010: bit k set means code k is a discounted item; width 2**UPC_W.
- EXP_MASK, 8'b1010_0001: bit k set means code k is an expensive item; width 2**UPC_W.
- ALARM_HOLD, 4: minimum number of cycles spent in ALARM; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; all state clears on a rising edge of clk while reset=1.
- in_valid  in  1  item presented.
- in_ready  out  1  block can accept an item.
- in_code  in  UPC_W  UPC code of the item.
- in_mark  in  1  security mark present on the item.
- clear  in  1  synchronous clear of the three counters only.
- alarm_ack  in  1  operator acknowledge of the alarm.
- disc  out  1  last item was discounted.
- stolen  out  1  last item was stolen.
- alarm  out  1  block is in ALARM.
- item_cnt, disc_cnt, stolen_cnt  out  CNT_W each  saturating counts of items, discounted items, and stolen items.

## Operation
- Classification:
  - discounted = DISC_MASK[code].
  - stolen = EXP_MASK[code] & ~mark.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, register code and mark, then go to CHECK.
  - CHECK: in_ready=0. Update disc and stolen. Increment item_cnt; increment disc_cnt if discounted; increment stolen_cnt if stolen. Go to ALARM if stolen, else IDLE.
  - ALARM: in_ready=0, alarm=1. The hold counter loads ALARM_HOLD-1 on entry and decrements each cycle. The exit rule is set by the configuration macro.
- Counters saturate at 2**CNT_W-1; they never wrap.
- clear:
  - Zeroes all three counters in any state.
  - If clear coincides with a CHECK update, clear wins: counters read 0 afterwards.
  - clear does not affect disc, stolen, alarm, or the state.
- in_code and in_mark are ignored whenever in_ready=0.
- Reset mid-operation (any state) returns to IDLE with every output at its reset value. A captured item is dropped and not counted.

## Timing
- Reset values:
  - in_ready=1 (registered with the state).
  - disc=0, stolen=0, alarm=0, all counters 0.
- Handshake at edge N. The block is in CHECK during cycle N+1, and the new flags and counts are visible from cycle N+2.
- Throughput is one item per 2 cycles when no alarm occurs.
- alarm rises in the cycle after CHECK. It stays high for at least ALARM_HOLD cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- alarm_ack is sampled only in ALARM. An ack before the hold expires is ignored and not remembered.

## Configuration
- UPC_ALARM_ACK_EN defined:
  - ALARM exits to IDLE on the first cycle with alarm_ack=1 and hold counter=0.
  - alarm stays high indefinitely until that happens.
- UPC_ALARM_ACK_EN undefined:
  - ALARM exits automatically after exactly ALARM_HOLD cycles.
  - alarm_ack port remains present but is ignored.

## Structure
- Package upc_pkg holds:
  - state enum (IDLE, CHECK, ALARM).
  - packed item struct {code, mark}.
  - default mask constants.
- Sub-module upc_classifier: combinational, parametrised by UPC_W, DISC_MASK, EXP_MASK; maps {code, mark} to {discounted, stolen}.
- The top block holds the FSM, item register, hold counter, and saturating counters.

## Test plan
- After reset, code=3'b001, mark=1, valid one cycle → two cycles later disc=1, stolen=0, item_cnt=1, disc_cnt=1, alarm=0, in_ready=1.
- code=3'b000, mark=0 → stolen=1, stolen_cnt=1. alarm high ≥4 cycles and in_ready=0 throughout. Then:
  - with UPC_ALARM_ACK_EN: ack at hold cycle 2 ignored; ack after expiry returns to IDLE next cycle.
  - without UPC_ALARM_ACK_EN: returns to IDLE after exactly 4 cycles.
- CNT_W=2, five back-to-back non-stolen items → item_cnt stops at 3, no wrap.
- clear asserted in the same cycle as CHECK → all counters 0, disc/stolen still reflect that item.
- reset asserted during CHECK and during ALARM → next cycle in IDLE, all outputs at reset values, item not counted.
- valid held high during ALARM with a changing code → no capture and no counter change until IDLE.
